reg_file_sb: RTL and testbench

Parametrised successor to the SLC-3 8x16 register file, sized for the pipelined datapath.
- Storage is NREGS registers of WIDTH bits, with two combinational read ports and one write port.
- Optional write-to-read bypass.
- Per-register pending-write scoreboard, so decode can detect RAW hazards.
- Sequenced register-clear engine for soft reinitialisation without asserting Reset.
- Sits between decode (SR1/SR2/issue) and writeback (D/DR/LD_REG).

---
 rtl/reg_file_sb_pkg.sv | 13 +
 rtl/reg_w.sv | 19 +
 rtl/reg_file_sb.sv | 117 +++++++++++
 tb/tb_reg_file_sb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and default sizing for the reg_file_sb register file slice.
package reg_file_sb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } clr_state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_PEND_W = 2;

endpackage

// File: rtl/reg_w.sv
// Generic WIDTH-bit load-enabled register with asynchronous active-high reset.
module reg_w #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Data_Out
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Data_Out <= '0;
    else if (Load)
      Data_Out <= D;
  end

endmodule

// File: rtl/reg_file_sb.sv
// NREGS x WIDTH register file with 2R/1W ports, optional write bypass,
// per-register pending-write scoreboard and a sequenced clear engine.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int PEND_W = DEF_PEND_W,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    DR,
  input  logic             LD_REG,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  input  logic             ISSUE,
  input  logic [AW-1:0]    ISSUE_DR,
  output logic             ISSUE_STALL,
  output logic             SR1_BUSY,
  output logic             SR2_BUSY,
  input  logic             CLEAR,
  output logic             CLR_BUSY
);

  clr_state_t        state, state_nxt;
  logic [AW-1:0]     idx;
  logic              idle;
  logic [NREGS-1:0]  we;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata [NREGS];
  logic [PEND_W-1:0] pend  [NREGS];
  logic [NREGS-1:0]  inc_v, dec_v;
  logic              fwd1, fwd2;

  // Clear FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= (state == IDLE) ? '0 : idx + 1'b1;
    end
  end

  // Clear FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLEAR) state_nxt = CLR;
      CLR:     if (idx == AW'(NREGS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    idle     = (state == IDLE);
    CLR_BUSY = (state == CLR);
  end

  // The clear engine reuses the normal write path, steering zero into reg[idx].
  always_comb begin
    wdata = idle ? D : '0;
    we    = '0;
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      we[i]    = idle ? (LD_REG && (DR == AW'(i))) : (idx == AW'(i));
      inc_v[i] = idle && ISSUE && !ISSUE_STALL && (ISSUE_DR == AW'(i));
      dec_v[i] = idle && LD_REG && (DR == AW'(i));
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    reg_w #(.WIDTH(WIDTH)) u_reg (
      .Clk      (Clk),
      .Reset    (Reset),
      .Load     (we[gi]),
      .D        (wdata),
      .Data_Out (rdata[gi])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (!idle && (idx == AW'(i)))
          pend[i] <= '0;
        else if (inc_v[i] && !dec_v[i])
          pend[i] <= pend[i] + 1'b1;
        else if (dec_v[i] && !inc_v[i] && (pend[i] != '0))
          pend[i] <= pend[i] - 1'b1;
      end
    end
  end

  // Early busy release is tied to forwarding, which only happens while idle.
  always_comb begin
    ISSUE_STALL = idle && ISSUE && (pend[ISSUE_DR] == '1);
    fwd1        = BYPASS && idle && LD_REG && (DR == SR1);
    fwd2        = BYPASS && idle && LD_REG && (DR == SR2);
    SR1_OUT     = fwd1 ? D : rdata[SR1];
    SR2_OUT     = fwd2 ? D : rdata[SR2];
    SR1_BUSY    = (pend[SR1] != '0) && !(fwd1 && (pend[SR1] == PEND_W'(1)));
    SR2_BUSY    = (pend[SR2] != '0) && !(fwd2 && (pend[SR2] == PEND_W'(1)));
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_reg_file_sb;

  logic        clk, rst;
  logic [15:0] d;
  logic [2:0]  dr, sr1, sr2, issue_dr;
  logic        ld, issue, clear;
  logic [15:0] sr1_out, sr2_out;
  logic        issue_stall, sr1_busy, sr2_busy, clr_busy;

  logic [31:0] b_d, b_sr1_out, b_sr2_out;
  logic [3:0]  b_dr, b_sr1, b_sr2, b_issue_dr;
  logic        b_ld, b_issue, b_clear;
  logic        b_issue_stall, b_sr1_busy, b_sr2_busy, b_clr_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_mem  [8];
  int          m_pend [8];
  bit          m_clr;
  int          m_idx;

  reg_file_sb dut (
    .Clk(clk), .Reset(rst), .D(d), .DR(dr), .LD_REG(ld),
    .SR1(sr1), .SR2(sr2), .SR1_OUT(sr1_out), .SR2_OUT(sr2_out),
    .ISSUE(issue), .ISSUE_DR(issue_dr), .ISSUE_STALL(issue_stall),
    .SR1_BUSY(sr1_busy), .SR2_BUSY(sr2_busy),
    .CLEAR(clear), .CLR_BUSY(clr_busy)
  );

  reg_file_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1'b0)) dut_b (
    .Clk(clk), .Reset(rst), .D(b_d), .DR(b_dr), .LD_REG(b_ld),
    .SR1(b_sr1), .SR2(b_sr2), .SR1_OUT(b_sr1_out), .SR2_OUT(b_sr2_out),
    .ISSUE(b_issue), .ISSUE_DR(b_issue_dr), .ISSUE_STALL(b_issue_stall),
    .SR1_BUSY(b_sr1_busy), .SR2_BUSY(b_sr2_busy),
    .CLEAR(b_clear), .CLR_BUSY(b_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 0;
    end
    m_clr = 1'b0;
    m_idx = 0;
  endtask

  task automatic check_all(input string tag);
    bit          idle, f1, f2, e_stall;
    logic [15:0] e1, e2;
    bit          b1, b2;
    idle    = !m_clr;
    f1      = idle && ld && (dr == sr1);
    f2      = idle && ld && (dr == sr2);
    e1      = f1 ? d : m_mem[sr1];
    e2      = f2 ? d : m_mem[sr2];
    b1      = (m_pend[sr1] != 0) && !(f1 && m_pend[sr1] == 1);
    b2      = (m_pend[sr2] != 0) && !(f2 && m_pend[sr2] == 1);
    e_stall = idle && issue && (m_pend[issue_dr] == 3);
    chk({tag, ".sr1_out"}, 32'(sr1_out), 32'(e1));
    chk({tag, ".sr2_out"}, 32'(sr2_out), 32'(e2));
    chk({tag, ".sr1_busy"}, 32'(sr1_busy), 32'(b1));
    chk({tag, ".sr2_busy"}, 32'(sr2_busy), 32'(b2));
    chk({tag, ".stall"}, 32'(issue_stall), 32'(e_stall));
    chk({tag, ".clr_busy"}, 32'(clr_busy), 32'(m_clr));
  endtask

  task automatic model_edge();
    bit stall;
    if (m_clr) begin
      m_mem[m_idx]  = '0;
      m_pend[m_idx] = 0;
      if (m_idx == 7) m_clr = 1'b0;
      else            m_idx++;
    end else begin
      stall = issue && (m_pend[issue_dr] == 3);
      if (ld) m_mem[dr] = d;
      for (int i = 0; i < 8; i++) begin
        bit inc, dec;
        inc = issue && !stall && (issue_dr == i);
        dec = ld && (dr == i);
        if (inc && !dec)                     m_pend[i]++;
        else if (dec && !inc && m_pend[i] > 0) m_pend[i]--;
      end
      if (clear) begin
        m_clr = 1'b1;
        m_idx = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Runs a clear from IDLE, holding CLEAR high for the whole sequence.
  task automatic run_clear(output int cnt);
    cnt   = 0;
    clear = 1'b1;
    tick("clr_start");
    for (int k = 0; k < 20; k++) begin
      if (!clr_busy) break;
      cnt++;
      clear = 1'b1;
      ld    = (cnt == 3);
      dr    = 3'd7;
      d     = 16'hFFFF;
      tick("clr_run");
    end
    clear = 1'b0;
    ld    = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 8; i++) begin
      ld = 1'b1;
      dr = 3'(i);
      d  = 16'(16'h1111 * i);
      tick("load");
    end
    ld = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; d = '0; dr = '0; ld = 1'b0; sr1 = '0; sr2 = '0;
    issue = 1'b0; issue_dr = '0; clear = 1'b0;
    b_d = '0; b_dr = '0; b_ld = 1'b0; b_sr1 = '0; b_sr2 = '0;
    b_issue = 1'b0; b_issue_dr = '0; b_clear = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick("reset");

    // Write with same-cycle forwarding, then async reset mid-cycle
    ld = 1'b1; dr = 3'd3; d = 16'hBEEF; sr1 = 3'd3;
    #1 chk("bypass_beef", 32'(sr1_out), 32'h0000BEEF);
    tick("wr3");
    ld = 1'b0;
    #1 chk("persist_beef", 32'(sr1_out), 32'h0000BEEF);
    #1 rst = 1'b1;
    #1 chk("async_rst_out", 32'(sr1_out), 32'h0);
    m_reset();
    #1 rst = 1'b0;
    @(negedge clk);

    // Saturate the pending counter of R5 and retire it
    issue = 1'b1; issue_dr = 3'd5; sr2 = 3'd5;
    tick("iss1");
    #1 chk("busy_after_issue", 32'(sr2_busy), 32'h1);
    tick("iss2");
    tick("iss3");
    #1 chk("stall_sat", 32'(issue_stall), 32'h1);
    tick("iss4");
    issue = 1'b0; ld = 1'b1; dr = 3'd5; d = 16'h5555;
    #1 chk("busy_w1", 32'(sr2_busy), 32'h1);
    tick("ret1");
    #1 chk("busy_w2", 32'(sr2_busy), 32'h1);
    tick("ret2");
    #1 chk("busy_w3_early", 32'(sr2_busy), 32'h0);
    tick("ret3");
    ld = 1'b0;
    #1 chk("busy_after_ret", 32'(sr2_busy), 32'h0);

    // Simultaneous issue and write on R2; untracked write on R6
    issue = 1'b1; issue_dr = 3'd2;
    tick("iss_r2");
    ld = 1'b1; dr = 3'd2; d = 16'h2222; sr1 = 3'd2;
    tick("iss_wr_r2");
    issue = 1'b0; ld = 1'b0;
    #1 chk("r2_still_busy", 32'(sr1_busy), 32'h1);
    ld = 1'b1; dr = 3'd6; d = 16'h1234;
    tick("wr6_untracked");
    ld = 1'b0; sr1 = 3'd6;
    #1 chk("r6_data", 32'(sr1_out), 32'h1234);
    chk("r6_not_busy", 32'(sr1_busy), 32'h0);
    ld = 1'b1; dr = 3'd2; d = 16'h2222;
    tick("retire_r2");
    ld = 1'b0;

    // Clear sequence with CLEAR held and a dropped write
    load_all();
    run_clear(cnt);
    chk("clr_cycles", 32'(cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1 chk("cleared_reg", 32'(sr1_out), 32'h0);
      tick("post_clr");
    end

    // Reset during clear cycle 3, then a fresh full clear
    load_all();
    clear = 1'b1;
    tick("clr2_start");
    clear = 1'b0;
    tick("clr2_c0");
    tick("clr2_c1");
    tick("clr2_c2");
    #2 rst = 1'b1;
    #1 chk("rst_mid_clr_busy", 32'(clr_busy), 32'h0);
    m_reset();
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      #1 chk("rst_mid_clr_reg", 32'(sr1_out), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick("after_rst");
    load_all();
    run_clear(cnt);
    chk("clr_cycles_again", 32'(cnt), 32'd8);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      d        = 16'($urandom);
      dr       = 3'($urandom_range(7));
      ld       = ($urandom_range(1) == 1);
      sr1      = 3'($urandom_range(7));
      sr2      = 3'($urandom_range(7));
      issue    = ($urandom_range(1) == 1);
      issue_dr = 3'($urandom_range(7));
      clear    = ($urandom_range(31) == 0);
      tick("rand");
    end
    ld = 1'b0; issue = 1'b0; clear = 1'b0;

    // Wide instance without bypass
    b_ld = 1'b1; b_dr = 4'd15; b_d = 32'hDEADBEEF; b_sr1 = 4'd15;
    #1 chk("b_no_bypass", b_sr1_out, 32'h0);
    @(posedge clk); @(negedge clk);
    b_ld = 1'b0;
    #1 chk("b_written", b_sr1_out, 32'hDEADBEEF);
    b_issue = 1'b1; b_issue_dr = 4'd15;
    @(posedge clk); @(negedge clk);
    b_issue = 1'b0;
    #1 chk("b_busy", 32'(b_sr1_busy), 32'h1);
    b_ld = 1'b1; b_d = 32'h00000001;
    #1 chk("b_no_early_clear", 32'(b_sr1_busy), 32'h1);
    chk("b_old_during_wr", b_sr1_out, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    b_ld = 1'b0;
    #1 chk("b_busy_retired", 32'(b_sr1_busy), 32'h0);
    chk("b_new_value", b_sr1_out, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
